apb_arbiter: RTL and testbench

//  Two-master APB arbiter sharing one downstream APB slave port between the cpu (master 0) and a

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_rr_picker.sv | 25 ++
 rtl/apb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the two-master APB arbiter: FSM state encoding,
// master count and byte-strobe constants.
// -----------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int unsigned NUM_MASTERS = 2;
    localparam int unsigned STB_WIDTH   = 4;
    localparam logic [STB_WIDTH-1:0] STB_ALL = 4'b1111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/apb_rr_picker.sv
// -----------------------------------------------------------------------------
// apb_rr_picker
// Combinational two-way round-robin pick.
//   req    in  2  request vector, bit N = master N
//   last   in  1  index of the master served most recently
//   gnt    out 2  one-hot winner, 0 when nobody requests
// On a tie the master that was not served last wins.
// -----------------------------------------------------------------------------
module apb_rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Shares one downstream APB slave port between the cpu (master 0) and a second
// requester (master 1). The granted upstream request is registered and replayed
// downstream as a full SETUP/ACCESS transfer; the result returns to the owner
// as a one-cycle m_pready pulse.
//
// Ports
//   APB_PCLK, APB_PRESET             clock, asynchronous active-high reset
//   m_psel/m_penable/m_pwrite [1:0]  upstream controls, bit N = master N
//   m_paddr, m_pdata, m_pstb         upstream fields, master N at slice N
//   m_prdata, m_pready, m_perr       upstream response (shared read data)
//   APB_paddr/pdata/pwrite/pstb      downstream request fields
//   APB_psel, APB_penable            downstream controls
//   APB_prdata, APB_pready, APB_perr downstream response
//   grant                            one-hot current owner, 0 when idle
//
// Configuration
//   APB_ARB_TIMEOUT_EN: when defined, an ACCESS phase that sees no APB_pready
//   for TIMEOUT_CYCLES cycles is terminated with an error response.
// -----------------------------------------------------------------------------
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                              APB_PCLK,
    input  logic                              APB_PRESET,
    input  logic [NUM_MASTERS-1:0]            m_psel,
    input  logic [NUM_MASTERS-1:0]            m_penable,
    input  logic [NUM_MASTERS-1:0]            m_pwrite,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pdata,
    input  logic [NUM_MASTERS*STB_WIDTH-1:0]  m_pstb,
    output logic [DATA_WIDTH-1:0]             m_prdata,
    output logic [NUM_MASTERS-1:0]            m_pready,
    output logic [NUM_MASTERS-1:0]            m_perr,
    output logic [ADDR_WIDTH-1:0]             APB_paddr,
    output logic [DATA_WIDTH-1:0]             APB_pdata,
    output logic                              APB_pwrite,
    output logic [STB_WIDTH-1:0]              APB_pstb,
    output logic                              APB_psel,
    output logic                              APB_penable,
    input  logic [DATA_WIDTH-1:0]             APB_prdata,
    input  logic                              APB_pready,
    input  logic                              APB_perr,
    output logic [NUM_MASTERS-1:0]            grant
);

    arb_state_e             state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   last_q, last_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic [STB_WIDTH-1:0]   stb_q, stb_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [1:0]             pick;
    logic                   pick_idx;

    // Upstream penable carries no information the arbiter needs: it captures
    // on psel alone and answers with m_pready.
    logic                   unused_penable;
    assign unused_penable = ^m_penable;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0]        cnt_q, cnt_d;
`endif

    apb_rr_picker u_picker (
        .req  (m_psel),
        .last (last_q),
        .gnt  (pick)
    );

    assign pick_idx = pick[1];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        stb_d   = stb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick != 2'b00) begin
                    grant_d = pick;
                    addr_d  = m_paddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = m_pdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    write_d = m_pwrite[pick_idx];
                    // Reads always present full strobes downstream.
                    stb_d   = m_pwrite[pick_idx] ? m_pstb[pick_idx*STB_WIDTH +: STB_WIDTH]
                                                 : STB_ALL;
                    state_d = StSetup;
                end
            end
            StSetup: begin
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StAccess;
            end
            StAccess: begin
                if (APB_pready) begin
                    rdata_d = APB_prdata;
                    err_d   = APB_perr;
                    state_d = StResp;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
        if (APB_PRESET) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            stb_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            stb_q   <= stb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
        if (APB_PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // All outputs decode from registered state, so reset clears them at once.
    always_comb begin
        APB_psel    = (state_q == StSetup) || (state_q == StAccess);
        APB_penable = (state_q == StAccess);
        APB_paddr   = addr_q;
        APB_pdata   = wdata_q;
        APB_pwrite  = write_q;
        APB_pstb    = stb_q;
        grant       = grant_q;
        m_pready    = 2'b00;
        m_perr      = 2'b00;
        m_prdata    = '0;
        if (state_q == StResp) begin
            m_pready = grant_q;
            m_perr   = grant_q & {2{err_q}};
            if (!write_q) begin
                m_prdata = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
// Directed bench for apb_arbiter with a response scoreboard and a simple
// programmable-wait APB slave.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;
    import apb_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        int          master;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     m_psel;
    logic [1:0]     m_penable = 2'b00;
    logic [1:0]     m_pwrite;
    logic [2*AW-1:0] m_paddr;
    logic [2*DW-1:0] m_pdata;
    logic [7:0]     m_pstb;
    logic [DW-1:0]  m_prdata;
    logic [1:0]     m_pready;
    logic [1:0]     m_perr;
    logic [AW-1:0]  APB_paddr;
    logic [DW-1:0]  APB_pdata;
    logic           APB_pwrite;
    logic [3:0]     APB_pstb;
    logic           APB_psel;
    logic           APB_penable;
    logic [DW-1:0]  APB_prdata = '0;
    logic           APB_pready = 1'b0;
    logic           APB_perr = 1'b0;
    logic [1:0]     grant;

    exp_t        sb[$];
    int          served[$];
    exp_t        mon_e;
    int          passed = 0;
    int          total = 0;
    int          pulses[2] = '{0, 0};
    int          slave_wait = 0;
    logic [31:0] slave_rdata = '0;
    logic        slave_err = 1'b0;
    int          acc_cnt = 0;
    int          last_acc = 0;
    bit          stab_chk = 1'b0;
    logic [31:0] stab_addr = '0;
    logic [31:0] stab_data = '0;
    int          p_before;

    apb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .APB_PCLK    (clk),
        .APB_PRESET  (rst),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwrite    (m_pwrite),
        .m_paddr     (m_paddr),
        .m_pdata     (m_pdata),
        .m_pstb      (m_pstb),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .m_perr      (m_perr),
        .APB_paddr   (APB_paddr),
        .APB_pdata   (APB_pdata),
        .APB_pwrite  (APB_pwrite),
        .APB_pstb    (APB_pstb),
        .APB_psel    (APB_psel),
        .APB_penable (APB_penable),
        .APB_prdata  (APB_prdata),
        .APB_pready  (APB_pready),
        .APB_perr    (APB_perr),
        .grant       (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) m_penable <= m_psel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Slave model and upstream response monitor, both sampling on negedge.
    always @(negedge clk) begin
        if (APB_psel && APB_penable) begin
            if (stab_chk) begin
                check("hold_paddr", 64'(APB_paddr), 64'(stab_addr));
                check("hold_pdata", 64'(APB_pdata), 64'(stab_data));
            end
            APB_pready = (acc_cnt == slave_wait);
            APB_prdata = slave_rdata;
            APB_perr   = slave_err;
            acc_cnt++;
        end else begin
            if (acc_cnt != 0) last_acc = acc_cnt;
            acc_cnt    = 0;
            APB_pready = 1'b0;
            APB_prdata = '0;
            APB_perr   = 1'b0;
        end

        if (m_pready != 2'b00) begin
            pulses[0] += int'(m_pready[0]);
            pulses[1] += int'(m_pready[1]);
            if (sb.size() == 0) begin
                check("unexpected_pready", 64'(m_pready), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("pready_owner", 64'(m_pready), 64'(2'b01 << mon_e.master));
                check("prdata", 64'(m_prdata), 64'(mon_e.rdata));
                check("perr", 64'(m_perr), 64'({1'b0, mon_e.err} << mon_e.master));
                served.push_back(mon_e.master);
            end
        end
    end

    task automatic req(input int m, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] stb);
        m_pwrite[m]          = wr;
        m_paddr[m*AW +: AW]  = addr;
        m_pdata[m*DW +: DW]  = data;
        m_pstb[m*4 +: 4]     = stb;
        m_psel[m]            = 1'b1;
    endtask

    task automatic push_exp(input int m, input logic [31:0] rd, input logic err);
        exp_t e;
        e.master = m;
        e.rdata  = rd;
        e.err    = err;
        sb.push_back(e);
    endtask

    // Waits for n responses; the requester drops psel once it has been served.
    task automatic wait_resp(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            while (served.size() > 0) begin
                int m;
                m = served.pop_front();
                m_psel[m] = 1'b0;
                got++;
            end
        end
        check("resp_count", 64'(got), 64'(n));
    endtask

    initial begin
        rst      = 1'b1;
        m_psel   = 2'b00;
        m_pwrite = 2'b00;
        m_paddr  = '0;
        m_pdata  = '0;
        m_pstb   = '0;
        repeat (2) @(negedge clk);
        check("rst_psel", 64'(APB_psel), 64'(0));
        check("rst_penable", 64'(APB_penable), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_pready", 64'(m_pready), 64'(0));
        check("rst_prdata", 64'(m_prdata), 64'(0));
        rst = 1'b0;

        // Simultaneous requests after reset: m0, m1, then m0, m1 again.
        @(negedge clk);
        slave_wait  = 0;
        slave_rdata = 32'h1111_1111;
        push_exp(0, 32'h1111_1111, 1'b0);
        push_exp(1, 32'h1111_1111, 1'b0);
        req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        req(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        @(negedge clk);
        check("t2_first_grant", 64'(grant), 64'(2'b01));
        wait_resp(2, 40);
        @(negedge clk);
        slave_rdata = 32'h2222_2222;
        push_exp(0, 32'h2222_2222, 1'b0);
        push_exp(1, 32'h2222_2222, 1'b0);
        req(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        req(1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        @(negedge clk);
        check("t2_second_grant", 64'(grant), 64'(2'b01));
        wait_resp(2, 40);

        // m0 read, zero-wait slave: psel +1, penable +2, pready +3.
        @(negedge clk);
        slave_rdata = 32'hDEAD_BEEF;
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        req(0, 1'b0, 32'h0000_1000, 32'h0, 4'b0011);
        @(negedge clk);
        check("t1_psel_p1", 64'(APB_psel), 64'(1));
        check("t1_penable_p1", 64'(APB_penable), 64'(0));
        check("t1_grant", 64'(grant), 64'(2'b01));
        check("t1_paddr", 64'(APB_paddr), 64'(32'h0000_1000));
        check("t1_pwrite", 64'(APB_pwrite), 64'(0));
        check("t1_pstb_read", 64'(APB_pstb), 64'(4'b1111));
        @(negedge clk);
        check("t1_penable_p2", 64'(APB_penable), 64'(1));
        @(negedge clk);
        check("t1_pready_p3", 64'(m_pready), 64'(2'b01));
        wait_resp(1, 5);

        // m1 write with 5 wait states; upstream fields change mid-transfer.
        @(negedge clk);
        slave_wait = 5;
        p_before   = pulses[1];
        push_exp(1, 32'h0, 1'b0);
        req(1, 1'b1, 32'h0000_2004, 32'h0000_00AA, 4'b0001);
        stab_addr = 32'h0000_2004;
        stab_data = 32'h0000_00AA;
        @(negedge clk);
        check("t3_grant", 64'(grant), 64'(2'b10));
        check("t3_pwrite", 64'(APB_pwrite), 64'(1));
        check("t3_pstb", 64'(APB_pstb), 64'(4'b0001));
        stab_chk = 1'b1;
        m_paddr[AW +: AW] = 32'hFFFF_FFFF;
        m_pdata[DW +: DW] = 32'h5555_5555;
        wait_resp(1, 20);
        stab_chk = 1'b0;
        check("t3_access_cycles", 64'(last_acc), 64'(6));
        repeat (3) @(negedge clk);
        check("t3_one_pulse", 64'(pulses[1]), 64'(p_before + 1));

        // Slave error on m0 read.
        @(negedge clk);
        slave_wait  = 0;
        slave_err   = 1'b1;
        slave_rdata = 32'h0;
        p_before    = pulses[1];
        push_exp(0, 32'h0, 1'b1);
        req(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        wait_resp(1, 10);
        slave_err = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_m1_no_pulse", 64'(pulses[1]), 64'(p_before));

        // Reset during ACCESS, then an m1-only request.
        slave_wait = 1000000;
        req(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        check("t5_in_access", 64'(APB_penable), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t5_rst_psel", 64'(APB_psel), 64'(0));
        check("t5_rst_penable", 64'(APB_penable), 64'(0));
        check("t5_rst_grant", 64'(grant), 64'(0));
        m_psel = 2'b00;
        @(negedge clk);
        rst         = 1'b0;
        slave_wait  = 0;
        slave_rdata = 32'h0000_0077;
        push_exp(1, 32'h0000_0077, 1'b0);
        req(1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        @(negedge clk);
        check("t5_m1_grant", 64'(grant), 64'(2'b10));
        wait_resp(1, 10);

        // Slave never ready.
        @(negedge clk);
        slave_wait  = 1000000;
        slave_rdata = 32'h9999_9999;
`ifdef APB_ARB_TIMEOUT_EN
        push_exp(0, 32'h0, 1'b1);
        req(0, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        wait_resp(1, 40);
        check("t6_timeout_cycles", 64'(last_acc), 64'(TO));
`else
        req(0, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        repeat (1000) @(negedge clk);
        check("t6_still_psel", 64'(APB_psel), 64'(1));
        check("t6_still_access", 64'(APB_penable), 64'(1));
        check("t6_no_pready", 64'(m_pready), 64'(0));
        rst    = 1'b1;
        m_psel = 2'b00;
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
